riscv_signature_writer: RTL and testbench

- Serialises signature traffic (core status, test result, CSR writes, full GPR dumps) from several requesters onto one write-only, memory-mapped signature port at a fixed address.
- Sits between the core-side debug/status logic and the testbench signature monitor.
- Provides fixed-priority arbitration, header/payload sequencing and valid/ready backpressure.
- Encodes words using the team's signature_type_t (CORE_STATUS=0, TEST_RESULT=1, WRITE_GPR=2, WRITE_CSR=3) and core_status_t values.

---
 rtl/riscv_signature_writer_if.sv | 24 ++
 rtl/riscv_signature_writer.sv | 198 +++++++++++++++++++
 tb/tb_riscv_signature_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_signature_writer_if.sv
// Signature write port: valid/ready handshake carrying one word
// to a fixed memory-mapped address.
interface riscv_signature_writer_if #(
  parameter int unsigned DataWidth = 32
) ();
  logic                 sig_valid_o;
  logic                 sig_ready_i;
  logic [31:0]          sig_addr_o;
  logic [DataWidth-1:0] sig_wdata_o;

  modport master (
    output sig_valid_o,
    output sig_addr_o,
    output sig_wdata_o,
    input  sig_ready_i
  );

  modport slave (
    input  sig_valid_o,
    input  sig_addr_o,
    input  sig_wdata_o,
    output sig_ready_i
  );
endinterface

// File: rtl/riscv_signature_writer.sv
// Arbitrates status/result/CSR/GPR-dump requesters onto a single
// write-only signature port with header/payload sequencing.
module riscv_signature_writer #(
  parameter int unsigned DataWidth = 32,
  parameter logic [31:0] SigAddr   = 32'h8FFF_FFF8,
  parameter int unsigned NumGpr    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 result_req_i,
  input  logic                 result_i,
  output logic                 result_ack_o,
  input  logic                 status_req_i,
  input  logic [4:0]           status_i,
  output logic                 status_ack_o,
  input  logic                 csr_req_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [DataWidth-1:0] csr_wdata_i,
  output logic                 csr_ack_o,
  input  logic                 gpr_req_i,
  output logic                 gpr_ack_o,
  output logic [4:0]           gpr_raddr_o,
  input  logic [DataWidth-1:0] gpr_rdata_i,
  output logic                 busy_o,
  riscv_signature_writer_if.master sig
);

  typedef enum logic [1:0] {
    CORE_STATUS = 2'd0,
    TEST_RESULT = 2'd1,
    WRITE_GPR   = 2'd2,
    WRITE_CSR   = 2'd3
  } signature_type_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CSR_DATA,
    GPR_DATA
  } state_t;

  localparam logic [4:0] LastIdx = 5'(NumGpr - 1);

  state_t               state_q, state_d;
  signature_type_t      kind_q, kind_d;
  logic                 result_q, result_d;
  logic [4:0]           status_q, status_d;
  logic [11:0]          csr_addr_q, csr_addr_d;
  logic [DataWidth-1:0] csr_wdata_q, csr_wdata_d;
  logic [4:0]           idx_q, idx_d;

  logic                 valid;
  logic [DataWidth-1:0] wdata;
  logic                 fire;

  function automatic logic [DataWidth-1:0] header(
    input signature_type_t kind,
    input logic            result,
    input logic [4:0]      status,
    input logic [11:0]     csr_addr
  );
    logic [DataWidth-1:0] w;
    w = '0;
    w[7:0] = {6'b0, kind};
    unique case (kind)
      CORE_STATUS: w[12:8] = status;
      TEST_RESULT: w[8]    = result;
      WRITE_CSR:   w[19:8] = csr_addr;
      WRITE_GPR:   ;
    endcase
    return w;
  endfunction

  assign fire            = valid && sig.sig_ready_i;
  assign sig.sig_valid_o = valid;
  assign sig.sig_wdata_o = wdata;
  assign sig.sig_addr_o  = SigAddr;
  assign busy_o          = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kind_q      <= CORE_STATUS;
      result_q    <= 1'b0;
      status_q    <= '0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      idx_q       <= '0;
    end else begin
      kind_q      <= kind_d;
      result_q    <= result_d;
      status_q    <= status_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    result_d     = result_q;
    status_d     = status_q;
    csr_addr_d   = csr_addr_q;
    csr_wdata_d  = csr_wdata_q;
    idx_d        = idx_q;
    valid        = 1'b0;
    wdata        = '0;
    gpr_raddr_o  = '0;
    result_ack_o = 1'b0;
    status_ack_o = 1'b0;
    csr_ack_o    = 1'b0;
    gpr_ack_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Fixed priority: result > status > csr > gpr.
        if (result_req_i) begin
          kind_d   = TEST_RESULT;
          result_d = result_i;
          state_d  = HDR;
        end else if (status_req_i) begin
          kind_d   = CORE_STATUS;
          status_d = status_i;
          state_d  = HDR;
        end else if (csr_req_i) begin
          kind_d      = WRITE_CSR;
          csr_addr_d  = csr_addr_i;
          csr_wdata_d = csr_wdata_i;
          state_d     = HDR;
        end else if (gpr_req_i) begin
          kind_d  = WRITE_GPR;
          state_d = HDR;
        end
      end

      HDR: begin
        valid = 1'b1;
        wdata = header(kind_q, result_q, status_q, csr_addr_q);
        if (fire) begin
          unique case (kind_q)
            TEST_RESULT: begin
              result_ack_o = 1'b1;
              state_d      = IDLE;
            end
            CORE_STATUS: begin
              status_ack_o = 1'b1;
              state_d      = IDLE;
            end
            WRITE_CSR: begin
              state_d = CSR_DATA;
            end
            WRITE_GPR: begin
              idx_d   = '0;
              state_d = GPR_DATA;
            end
          endcase
        end
      end

      CSR_DATA: begin
        valid = 1'b1;
        wdata = csr_wdata_q;
        if (fire) begin
          csr_ack_o = 1'b1;
          state_d   = IDLE;
        end
      end

      GPR_DATA: begin
        // Register file is frozen during a dump, so read data is
        // forwarded combinationally and stays stable under stall.
        valid       = 1'b1;
        gpr_raddr_o = idx_q;
        wdata       = gpr_rdata_i;
        if (fire) begin
          if (idx_q == LastIdx) begin
            gpr_ack_o = 1'b1;
            idx_d     = '0;
            state_d   = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_signature_writer.sv
// Self-checking bench: vector table, hand sequences and randomized
// request/backpressure runs against a transaction-level model.
module tb_riscv_signature_writer;

  localparam int          DW = 32;
  localparam int          NG = 32;
  localparam logic [31:0] SA = 32'h8FFF_FFF8;

  localparam logic [3:0] A_RES = 4'b1000;
  localparam logic [3:0] A_STA = 4'b0100;
  localparam logic [3:0] A_CSR = 4'b0010;
  localparam logic [3:0] A_GPR = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          result_req, result, result_ack;
  logic          status_req, status_ack;
  logic [4:0]    status;
  logic          csr_req, csr_ack;
  logic [11:0]   csr_addr;
  logic [DW-1:0] csr_wdata;
  logic          gpr_req, gpr_ack;
  logic [4:0]    gpr_raddr;
  logic [DW-1:0] gpr_rdata;
  logic          busy;
  logic [DW-1:0] regs [NG];

  always #5 clk = ~clk;

  riscv_signature_writer_if #(.DataWidth(DW)) sig ();

  assign gpr_rdata = regs[gpr_raddr];

  riscv_signature_writer #(
    .DataWidth(DW),
    .SigAddr(SA),
    .NumGpr(NG)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .result_req_i(result_req),
    .result_i(result),
    .result_ack_o(result_ack),
    .status_req_i(status_req),
    .status_i(status),
    .status_ack_o(status_ack),
    .csr_req_i(csr_req),
    .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata),
    .csr_ack_o(csr_ack),
    .gpr_req_i(gpr_req),
    .gpr_ack_o(gpr_ack),
    .gpr_raddr_o(gpr_raddr),
    .gpr_rdata_i(gpr_rdata),
    .busy_o(busy),
    .sig(sig)
  );

  typedef struct {
    logic [DW-1:0] w;
    logic [3:0]    ack;
  } xfer_t;

  typedef struct {
    logic [3:0]  mask;
    logic        r;
    logic [4:0]  st;
    logic [11:0] ca;
    logic [31:0] cd;
    logic [31:0] hdr;
    int          n;
  } vec_t;

  xfer_t         got_q[$];
  xfer_t         exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            busy_cnt, cyc, stall_left, rmode;
  logic          hold, last_valid;
  logic [DW-1:0] held_w;
  logic [3:0]    prev_ack;
  vec_t          tbl[7];

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
               $time);
    end
  endfunction

  // Model: the words a single request produces, acked on its last word.
  task automatic expect_req(int k);
    case (k)
      3: exp_q.push_back('{32'h1 + (result ? 32'h100 : 32'h0), A_RES});
      2: exp_q.push_back('{32'(status) << 8, A_STA});
      1: begin
        exp_q.push_back('{(32'(csr_addr) << 8) | 32'h3, 4'b0});
        exp_q.push_back('{csr_wdata, A_CSR});
      end
      default: begin
        exp_q.push_back('{32'h2, 4'b0});
        for (int i = 0; i < NG; i++)
          exp_q.push_back('{regs[i], (i == NG - 1) ? A_GPR : 4'b0});
      end
    endcase
  endtask

  task automatic set_ready();
    if (stall_left > 0) begin
      sig.sig_ready_i = 1'b0;
      stall_left--;
    end else begin
      case (rmode)
        0: sig.sig_ready_i = 1'b1;
        1: sig.sig_ready_i = ~sig.sig_ready_i;
        default: sig.sig_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic step();
    logic       v, xf;
    logic [3:0] ack;
    @(negedge clk);
    v   = sig.sig_valid_o;
    xf  = v && sig.sig_ready_i;
    ack = {result_ack, status_ack, csr_ack, gpr_ack};
    if (hold) begin
      check("hold_valid", 32'(v), 32'd1);
      check("hold_data", sig.sig_wdata_o, held_w);
    end
    if (prev_ack != 4'b0) check("gap_idle", 32'(v), 32'd0);
    if (!xf) check("stray_ack", 32'(ack), 32'd0);
    if (v) check("addr", sig.sig_addr_o, SA);
    check("busy_vs_valid", 32'(busy), 32'(v));
    if (xf) got_q.push_back('{sig.sig_wdata_o, ack});
    busy_cnt  += int'(busy);
    hold       = v && !sig.sig_ready_i;
    held_w     = sig.sig_wdata_o;
    prev_ack   = xf ? ack : 4'b0;
    last_valid = v;
    @(posedge clk);
    #1;
    if (ack[3]) result_req = 1'b0;
    if (ack[2]) status_req = 1'b0;
    if (ack[1]) csr_req    = 1'b0;
    if (ack[0]) gpr_req    = 1'b0;
    set_ready();
  endtask

  task automatic run_seq(logic [3:0] mask, int mode, int stall);
    got_q.delete();
    exp_q.delete();
    for (int k = 3; k >= 0; k--) if (mask[k]) expect_req(k);
    rmode      = mode;
    stall_left = stall;
    if (mode == 1) sig.sig_ready_i = 1'b1;
    set_ready();
    {result_req, status_req, csr_req, gpr_req} = mask;
    busy_cnt = 0;
    cyc      = 0;
    while ((result_req || status_req || csr_req || gpr_req) &&
           cyc < 500) begin
      step();
      cyc++;
      if (cyc == 1) check("grant_latency", 32'(last_valid), 32'd0);
    end
    if (result_req || status_req || csr_req || gpr_req)
      check("timeout", 32'd1, 32'd0);
    check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        check($sformatf("word%0d", i), got_q[i].w, exp_q[i].w);
        check($sformatf("ack%0d", i), 32'(got_q[i].ack),
              32'(exp_q[i].ack));
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_valid"}, 32'(sig.sig_valid_o), 32'd0);
    check({tag, "_wdata"}, sig.sig_wdata_o, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_raddr"}, 32'(gpr_raddr), 32'd0);
    check({tag, "_acks"},
          32'({result_ack, status_ack, csr_ack, gpr_ack}), 32'd0);
  endtask

  initial begin
    tbl[0] = '{A_STA, 1'b0, 5'd2,  12'h0,   32'h0,       32'h0000_0200, 1};
    tbl[1] = '{A_RES, 1'b1, 5'd0,  12'h0,   32'h0,       32'h0000_0101, 1};
    tbl[2] = '{A_RES, 1'b0, 5'd0,  12'h0,   32'h0,       32'h0000_0001, 1};
    tbl[3] = '{A_STA, 1'b0, 5'd31, 12'h0,   32'h0,       32'h0000_1F00, 1};
    tbl[4] = '{A_CSR, 1'b0, 5'd0,  12'h300, 32'h1888,    32'h0003_0003, 2};
    tbl[5] = '{A_CSR, 1'b0, 5'd0,  12'hFFF, 32'hFFFF_FFFF, 32'h000F_FF03, 2};
    tbl[6] = '{A_GPR, 1'b0, 5'd0,  12'h0,   32'h0,       32'h0000_0002, 33};

    for (int i = 0; i < NG; i++) regs[i] = 32'(i * 4);
    rst = 1'b1;
    {result_req, status_req, csr_req, gpr_req} = 4'b0;
    result = 1'b0;
    status = '0;
    csr_addr = '0;
    csr_wdata = '0;
    sig.sig_ready_i = 1'b1;
    hold = 1'b0;
    prev_ack = 4'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-request vectors with ready held high.
    for (int t = 0; t < 7; t++) begin
      result = tbl[t].r;
      status = tbl[t].st;
      csr_addr = tbl[t].ca;
      csr_wdata = tbl[t].cd;
      run_seq(tbl[t].mask, 0, 0);
      check($sformatf("tbl%0d_n", t), 32'(got_q.size()), 32'(tbl[t].n));
      if (got_q.size() > 0)
        check($sformatf("tbl%0d_hdr", t), got_q[0].w, tbl[t].hdr);
      check($sformatf("tbl%0d_busy", t), 32'(busy_cnt), 32'(tbl[t].n));
    end

    // CSR pair with ready toggling every cycle.
    csr_addr = 12'h300;
    csr_wdata = 32'h0000_1888;
    run_seq(A_CSR, 1, 0);

    // All four requesters at once.
    result = 1'b1;
    status = 5'd2;
    csr_addr = 12'h7C0;
    csr_wdata = 32'hDEAD_BEEF;
    run_seq(4'b1111, 0, 0);

    // Result held in HDR under 20 stalled cycles.
    result = 1'b0;
    run_seq(A_RES, 0, 21);
    check("stall_cycles", 32'(cyc), 32'd22);

    // Reset in the middle of a GPR dump.
    got_q.delete();
    rmode = 0;
    stall_left = 0;
    sig.sig_ready_i = 1'b1;
    gpr_req = 1'b1;
    cyc = 0;
    while (got_q.size() < 10 && cyc < 100) begin
      step();
      cyc++;
    end
    check("pre_rst_words", 32'(got_q.size()), 32'd10);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    gpr_req = 1'b0;
    hold = 1'b0;
    prev_ack = 4'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_valid", 32'(sig.sig_valid_o), 32'd0);
      check("rst_no_ack", 32'(gpr_ack), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    status = 5'd2;
    run_seq(A_STA, 0, 0);

    // Random requester sets, payloads and backpressure.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NG; i++) regs[i] = $urandom;
      result = 1'($urandom);
      status = 5'($urandom);
      csr_addr = 12'($urandom);
      csr_wdata = $urandom;
      run_seq(4'($urandom_range(1, 15)), 2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
